reg16_uart_reader: RTL and testbench

Debug readback transmitter for the 16-bit register datapath. A one-cycle start pulse snapshots a 16-bit register value, which is then sent out a UART TX pin as two 8N1 bytes. This is the read/observe side of the write-enabled 16-bit register. It sits between any register output bus and the board's serial pin, so register contents can be inspected on a host.

---
 rtl/reg16_uart_pkg.sv | 30 +++
 rtl/reg16_uart_reader_baud.sv | 34 +++
 rtl/reg16_uart_reader.sv | 148 ++++++++++++++
 tb/tb_reg16_uart_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg16_uart_pkg.sv
// reg16_uart_pkg
// Shared definitions for the 16-bit register UART readback path.
//   uart_state_t   : transmitter FSM states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS : data bits per 8N1 character
//   BYTES_PER_WORD : characters sent per 16-bit register snapshot
//   select_byte()  : picks the byte that goes out for a given byte slot
package reg16_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 2;

  // byte_idx is the slot in transmission order (0 = first byte on the wire).
  // With hi_first clear the low byte leads; with it set the high byte leads.
  function automatic logic [7:0] select_byte(input logic [15:0] word,
                                             input logic        byte_idx,
                                             input logic        hi_first);
    if (byte_idx ^ hi_first)
      return word[15:8];
    else
      return word[7:0];
  endfunction

endpackage

// File: rtl/reg16_uart_reader_baud.sv
// uart_baud_tick
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick is high during
// the last count of each bit period, so a state change clocked on tick lands
// exactly on the bit boundary.
//   clk   : system clock
//   reset : asynchronous, active-high
//   clear : restart the bit period from count 0 on the next edge
//   tick  : one-cycle pulse in the final cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (clear || (count_reg == LAST))
      count_reg <= '0;
    else
      count_reg <= count_reg + CNT_W'(1);
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/reg16_uart_reader.sv
// reg16_uart_reader
// Debug readback transmitter: a start pulse snapshots a 16-bit register value
// and sends it out txd as two back-to-back 8N1 characters.
//   clk     : system clock, all state on posedge
//   reset   : asynchronous, active-high
//   start   : request pulse, honoured only while idle
//   regData : register value, captured on the accepting edge
//   busy    : high from the cycle after acceptance until the frame ends
//   done    : one-cycle pulse after the final stop bit
//   txd     : serial output, idle high
module reg16_uart_reader
  import reg16_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int HI_FIRST     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] regData,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  localparam int BIT_IDX_W  = $clog2(UART_DATA_BITS);
  localparam int BYTE_IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(UART_DATA_BITS - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);
  localparam logic HI_FIRST_BIT = (HI_FIRST != 0);

  uart_state_t           state_reg, state_next;
  logic [15:0]           shadow_reg, shadow_next;
  logic [BIT_IDX_W-1:0]  bit_reg, bit_next;
  logic [BYTE_IDX_W-1:0] byte_reg, byte_next;
  logic                  txd_reg, txd_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;

  logic                  baud_clear;
  logic                  baud_tick;
  logic [7:0]            cur_byte;
  logic [BIT_IDX_W-1:0]  bit_inc;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  assign cur_byte = select_byte(shadow_reg, byte_reg[0], HI_FIRST_BIT);
  assign bit_inc  = bit_reg + BIT_IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      bit_reg    <= '0;
      byte_reg   <= '0;
      txd_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      bit_reg    <= bit_next;
      byte_reg   <= byte_next;
      txd_reg    <= txd_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // txd_next carries the level of the bit that starts on the coming edge,
  // so txd itself is a plain flop output with no decode glitches.
  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    bit_next    = bit_reg;
    byte_next   = byte_reg;
    txd_next    = txd_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    baud_clear  = 1'b0;

    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        if (start) begin
          shadow_next = regData;
          bit_next    = '0;
          byte_next   = '0;
          baud_clear  = 1'b1;
          txd_next    = 1'b0;
          busy_next   = 1'b1;
          state_next  = START;
        end
      end

      START: begin
        if (baud_tick) begin
          bit_next   = '0;
          txd_next   = cur_byte[0];
          state_next = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_reg == LAST_BIT) begin
            txd_next   = 1'b1;
            state_next = STOP;
          end else begin
            bit_next = bit_inc;
            txd_next = cur_byte[bit_inc];
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (byte_reg == LAST_BYTE) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            // Next character starts immediately, no idle gap.
            byte_next  = byte_reg + BYTE_IDX_W'(1);
            txd_next   = 1'b0;
            state_next = START;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign txd  = txd_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_reg16_uart_reader.sv
// tb_reg16_uart_reader
// Directed bench for reg16_uart_reader with CLKS_PER_BIT=4. dut0 sends the
// low byte first, dut1 the high byte first. Each frame is logged cycle by
// cycle (cycle 1 = first cycle after the accepting edge) and bit levels are
// read at the centre of each 4-cycle bit.
module tb_reg16_uart_reader;

  localparam int CPB = 4;

  logic        clk;
  logic        reset;
  logic        start0, start1;
  logic [15:0] data0, data1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic        txd0, txd1;

  int checks;
  int failures;

  logic tx_log   [0:199];
  logic busy_log [0:199];
  logic done_log [0:199];

  reg16_uart_reader #(.CLKS_PER_BIT(CPB), .HI_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .regData(data0),
    .busy(busy0), .done(done0), .txd(txd0)
  );

  reg16_uart_reader #(.CLKS_PER_BIT(CPB), .HI_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .regData(data1),
    .busy(busy1), .done(done1), .txd(txd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte whose first data bit is wire bit first_bit (bit b spans cycles 4b+1..4b+4).
  function automatic logic [7:0] decode(input int first_bit);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[i] = tx_log[(first_bit + i) * CPB + 2];
    return v;
  endfunction

  function automatic int count_ones_done(input int ncyc);
    int n;
    n = 0;
    for (int c = 1; c <= ncyc; c++)
      if (done_log[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_ones_busy(input int ncyc);
    int n;
    n = 0;
    for (int c = 1; c <= ncyc; c++)
      if (busy_log[c] === 1'b1) n++;
    return n;
  endfunction

  // Applies start/regData for the accepting edge; returns at cycle 1 + #1.
  task automatic pulse_start(input bit sel, input logic [15:0] d);
    @(posedge clk); #1;
    if (sel == 1'b0) begin start0 = 1'b1; data0 = d; end
    else             begin start1 = 1'b1; data1 = d; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Logs ncyc cycles. Optional start injection at inj_cycle, start held for
  // every cycle (hold), or regData randomised every cycle (scramble).
  task automatic capture(input bit sel, input int ncyc, input int inj_cycle,
                         input logic [15:0] inj_data, input bit hold,
                         input bit scramble);
    for (int c = 1; c <= ncyc; c++) begin
      if (sel == 1'b0) begin
        start0 = hold || (c == inj_cycle);
        if (scramble) data0 = 16'($urandom);
        if (c == inj_cycle) data0 = inj_data;
      end else begin
        start1 = hold || (c == inj_cycle);
        if (scramble) data1 = 16'($urandom);
        if (c == inj_cycle) data1 = inj_data;
      end
      @(negedge clk);
      if (sel == 1'b0) begin
        tx_log[c] = txd0; busy_log[c] = busy0; done_log[c] = done0;
      end else begin
        tx_log[c] = txd1; busy_log[c] = busy1; done_log[c] = done1;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    data0 = '0; data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({txd0, busy0, done0, txd1, busy1, done1} !== 6'b100100) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=100100",
               {txd0, busy0, done0, txd1, busy1, done1});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_lo_first;
    pulse_start(1'b0, 16'hA55A);
    capture(1'b0, 84, 0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (tx_log[1] !== 1'b0) begin
      failures++; $display("FAIL lo_first_start_bit_cycle1 got=%b expected=0", tx_log[1]);
    end
    checks++;
    if (decode(1) !== 8'h5A) begin
      failures++; $display("FAIL lo_first_byte0 got=%h expected=5a", decode(1));
    end
    checks++;
    if (decode(11) !== 8'hA5) begin
      failures++; $display("FAIL lo_first_byte1 got=%h expected=a5", decode(11));
    end
    checks++;
    if ({tx_log[9*CPB+2], tx_log[10*CPB+2], tx_log[19*CPB+2]} !== 3'b101) begin
      failures++;
      $display("FAIL lo_first_framing got=%b expected=101",
               {tx_log[9*CPB+2], tx_log[10*CPB+2], tx_log[19*CPB+2]});
    end
    checks++;
    if (count_ones_busy(84) !== 80 || busy_log[80] !== 1'b1 || busy_log[81] !== 1'b0) begin
      failures++;
      $display("FAIL lo_first_busy_len got=%0d expected=80 (cycles 1..80)", count_ones_busy(84));
    end
    checks++;
    if (done_log[81] !== 1'b1 || count_ones_done(84) !== 1) begin
      failures++;
      $display("FAIL lo_first_done got=%b/%0d expected=1 at cycle 81, one pulse",
               done_log[81], count_ones_done(84));
    end
  endtask

  task automatic test_hi_first;
    pulse_start(1'b1, 16'h1234);
    capture(1'b1, 84, 0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (decode(1) !== 8'h12) begin
      failures++; $display("FAIL hi_first_byte0 got=%h expected=12", decode(1));
    end
    checks++;
    if (decode(11) !== 8'h34) begin
      failures++; $display("FAIL hi_first_byte1 got=%h expected=34", decode(11));
    end
    checks++;
    if (done_log[81] !== 1'b1 || count_ones_done(84) !== 1) begin
      failures++; $display("FAIL hi_first_done got=%b expected=1 at cycle 81", done_log[81]);
    end
  endtask

  task automatic test_start_while_busy;
    pulse_start(1'b0, 16'hA55A);
    capture(1'b0, 84, 30, 16'hFFFF, 1'b0, 1'b0);
    checks++;
    if ({decode(1), decode(11)} !== 16'h5AA5) begin
      failures++;
      $display("FAIL ignore_busy_bytes got=%h expected=5aa5", {decode(1), decode(11)});
    end
    checks++;
    if (count_ones_done(84) !== 1 || tx_log[84] !== 1'b1) begin
      failures++;
      $display("FAIL ignore_busy_single_frame done_pulses=%0d txd84=%b expected=1/1",
               count_ones_done(84), tx_log[84]);
    end
  endtask

  task automatic test_back_to_back;
    int total_done;
    pulse_start(1'b0, 16'h00FF);
    capture(1'b0, 81, 0, 16'h00FF, 1'b1, 1'b0);
    total_done = count_ones_done(81);
    checks++;
    if ({decode(1), decode(11)} !== 16'hFF00 || done_log[81] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_frame1 got=%h done81=%b expected=ff00/1",
               {decode(1), decode(11)}, done_log[81]);
    end
    capture(1'b0, 84, 0, 16'h0, 1'b0, 1'b0);
    total_done += count_ones_done(84);
    checks++;
    if (tx_log[1] !== 1'b0 || busy_log[1] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart got txd=%b busy=%b expected txd=0 busy=1", tx_log[1], busy_log[1]);
    end
    checks++;
    if ({decode(1), decode(11)} !== 16'hFF00) begin
      failures++; $display("FAIL b2b_frame2 got=%h expected=ff00", {decode(1), decode(11)});
    end
    checks++;
    if (total_done !== 2) begin
      failures++; $display("FAIL b2b_done_count got=%0d expected=2", total_done);
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    pulse_start(1'b0, 16'hA55A);
    capture(1'b0, 50, 0, 16'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({txd0, busy0, done0} !== 3'b100) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b expected=100", {txd0, busy0, done0});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || txd0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL reset_abandons_frame got=%0d bad cycles expected=0", bad);
    end
    pulse_start(1'b0, 16'h1234);
    capture(1'b0, 84, 0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({decode(1), decode(11)} !== 16'h3412 || count_ones_done(84) !== 1) begin
      failures++;
      $display("FAIL post_reset_frame got=%h done=%0d expected=3412/1",
               {decode(1), decode(11)}, count_ones_done(84));
    end
  endtask

  task automatic test_data_change;
    pulse_start(1'b0, 16'hBEEF);
    capture(1'b0, 84, 0, 16'h0, 1'b0, 1'b1);
    checks++;
    if ({decode(1), decode(11)} !== 16'hEFBE) begin
      failures++;
      $display("FAIL shadow_stable got=%h expected=efbe", {decode(1), decode(11)});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_lo_first;
    test_hi_first;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_frame;
    test_data_change;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
